// File: rtl/approx_char_pkg.sv
// Shared types and width helpers for the approximate-adder
// error characterisation stage.
package approx_char_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int err_w(input int w);
    return w + 1;
  endfunction

  function automatic int sq_w(input int w);
    return 2 * (w + 1);
  endfunction

  function automatic int sum_abs_w(input int w, input int l);
    return w + 1 + l;
  endfunction

  function automatic int sum_sq_w(input int w, input int l);
    return 2 * (w + 1) + l;
  endfunction

  function automatic int cnt_w(input int l);
    return l + 1;
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Two-stage error datapath: S1 forms |exact - o|,
// S2 squares it. Fixed latency, no backpressure.
module approx_err_calc
  import approx_char_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [WIDTH:0]       o_i,
  output logic                 valid_o,
  output logic [WIDTH:0]       err_o,
  output logic [2*WIDTH+1:0]   err_sq_o
);

  localparam int EW  = err_w(WIDTH);
  localparam int SQW = sq_w(WIDTH);

  logic [EW-1:0]     exact;
  logic signed [EW:0] diff;
  logic [EW-1:0]     err_d;
  logic [EW-1:0]     err_q;
  logic              v1_q;
  logic [EW-1:0]     err2_q;
  logic [SQW-1:0]    sq_q;
  logic [SQW-1:0]    sq_d;
  logic              v2_q;

  // o may lie outside the true sum range, so the
  // difference needs one extra sign bit.
  always_comb begin
    exact = EW'(a_i) + EW'(b_i);
    diff  = $signed({1'b0, exact}) - $signed({1'b0, o_i});
    err_d = diff[EW] ? EW'(-diff) : diff[EW-1:0];
    sq_d  = SQW'(err_q) * SQW'(err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      err_q  <= '0;
      v2_q   <= 1'b0;
      err2_q <= '0;
      sq_q   <= '0;
    end else begin
      v1_q   <= valid_i;
      err_q  <= err_d;
      v2_q   <= v1_q;
      err2_q <= err_q;
      sq_q   <= sq_d;
    end
  end

  assign valid_o  = v2_q;
  assign err_o    = err2_q;
  assign err_sq_o = sq_q;

endmodule

// File: rtl/approx_add_err_char.sv
// Windowed MAE/WCE/EP/MSE statistics for an approximate adder,
// held for the host until acknowledged.
module approx_add_err_char
  import approx_char_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic [WIDTH:0]              in_o,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ack,
  output logic [WIDTH+LOG2_N:0]       res_sum_abs,
  output logic [WIDTH:0]              res_mae,
  output logic [WIDTH:0]              res_wce,
  output logic [LOG2_N:0]             res_err_cnt,
  output logic [2*WIDTH+1+LOG2_N:0]   res_sum_sq,
  output logic [2*WIDTH+1:0]          res_mse
);

  localparam int EW  = err_w(WIDTH);
  localparam int SQW = sq_w(WIDTH);
  localparam int SAW = sum_abs_w(WIDTH, LOG2_N);
  localparam int SSW = sum_sq_w(WIDTH, LOG2_N);
  localparam int CW  = cnt_w(LOG2_N);
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            dly_q;
  logic            rv_q;

  logic [SAW-1:0]  sabs_q, sabs_d;
  logic [SSW-1:0]  ssq_q, ssq_d;
  logic [CW-1:0]   ecnt_q, ecnt_d;
  logic [EW-1:0]   wce_q, wce_d;

  logic [SAW-1:0]  r_sabs_q;
  logic [SSW-1:0]  r_ssq_q;
  logic [CW-1:0]   r_ecnt_q;
  logic [EW-1:0]   r_wce_q;

  logic            accept;
  logic            p_v;
  logic [EW-1:0]   p_err;
  logic [SQW-1:0]  p_sq;

  assign accept = in_valid && (state_q == RUN);

  approx_err_calc #(.WIDTH(WIDTH)) u_calc (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (accept),
    .a_i      (in_a),
    .b_i      (in_b),
    .o_i      (in_o),
    .valid_o  (p_v),
    .err_o    (p_err),
    .err_sq_o (p_sq)
  );

  always_comb begin
    sabs_d = sabs_q;
    ssq_d  = ssq_q;
    ecnt_d = ecnt_q;
    wce_d  = wce_q;
    if (state_q == IDLE && start) begin
      sabs_d = '0;
      ssq_d  = '0;
      ecnt_d = '0;
      wce_d  = '0;
    end else if (p_v) begin
      sabs_d = sabs_q + SAW'(p_err);
      ssq_d  = ssq_q + SSW'(p_sq);
      ecnt_d = ecnt_q + CW'(p_err != '0);
      if (p_err > wce_q) wce_d = p_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dly_q    <= 1'b0;
      rv_q     <= 1'b0;
      sabs_q   <= '0;
      ssq_q    <= '0;
      ecnt_q   <= '0;
      wce_q    <= '0;
      r_sabs_q <= '0;
      r_ssq_q  <= '0;
      r_ecnt_q <= '0;
      r_wce_q  <= '0;
    end else begin
      sabs_q <= sabs_d;
      ssq_q  <= ssq_d;
      ecnt_q <= ecnt_d;
      wce_q  <= wce_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= DRAIN;
              dly_q   <= 1'b0;
            end
          end
        end
        // Last sample reaches S2 on the second drain cycle;
        // latch the accumulators' next values on that edge.
        DRAIN: begin
          dly_q <= 1'b1;
          if (dly_q) begin
            state_q  <= DONE;
            rv_q     <= 1'b1;
            r_sabs_q <= sabs_d;
            r_ssq_q  <= ssq_d;
            r_ecnt_q <= ecnt_d;
            r_wce_q  <= wce_d;
          end
        end
        DONE: begin
          if (res_ack) begin
            state_q <= IDLE;
            rv_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == RUN);
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign res_valid   = rv_q;
  assign res_sum_abs = r_sabs_q;
  assign res_mae     = r_sabs_q[SAW-1:LOG2_N];
  assign res_wce     = r_wce_q;
  assign res_err_cnt = r_ecnt_q;
  assign res_sum_sq  = r_ssq_q;
  assign res_mse     = r_ssq_q[SSW-1:LOG2_N];

endmodule

// File: tb/tb_approx_add_err_char.sv
// Bench: LOG2_N=2 instance vs a windowed statistics model,
// plus an exhaustive 8x8 sweep on a LOG2_N=16 instance.
module tb_approx_add_err_char;

  localparam int L = 2;
  localparam int N = 1 << L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, res_ack;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_o;
  logic        in_ready, busy, res_valid;
  logic [10:0] r_sabs;
  logic [8:0]  r_mae, r_wce;
  logic [2:0]  r_cnt;
  logic [19:0] r_ssq;
  logic [17:0] r_mse;

  logic        bstart, bvalid, back;
  logic [7:0]  ba, bb;
  logic [8:0]  bo;
  logic        b_ready, b_busy, b_rv;
  logic [24:0] b_sabs;
  logic [8:0]  b_mae, b_wce;
  logic [16:0] b_cnt;
  logic [33:0] b_ssq;
  logic [17:0] b_mse;

  approx_add_err_char #(.WIDTH(8), .LOG2_N(L)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
    .res_sum_abs(r_sabs), .res_mae(r_mae), .res_wce(r_wce),
    .res_err_cnt(r_cnt), .res_sum_sq(r_ssq), .res_mse(r_mse)
  );

  approx_add_err_char #(.WIDTH(8), .LOG2_N(16)) dut_big (
    .clk(clk), .rst(rst), .start(bstart),
    .in_valid(bvalid), .in_ready(b_ready),
    .in_a(ba), .in_b(bb), .in_o(bo),
    .busy(b_busy), .res_valid(b_rv), .res_ack(back),
    .res_sum_abs(b_sabs), .res_mae(b_mae), .res_wce(b_wce),
    .res_err_cnt(b_cnt), .res_sum_sq(b_ssq), .res_mse(b_mse)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase + list of window errors
  int     m_ph = 0;
  int     due = -1;
  int     cyc = 0;
  int     win[$];
  logic   m_ready = 0, m_busy = 0, m_rv = 0;
  longint m_sum = 0, m_wce = 0, m_cnt = 0, m_sq = 0;

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("res_valid", res_valid, m_rv);
    chk("sum_abs", r_sabs, m_sum);
    chk("mae", r_mae, m_sum >> L);
    chk("wce", r_wce, m_wce);
    chk("err_cnt", r_cnt, m_cnt);
    chk("sum_sq", r_ssq, m_sq);
    chk("mse", r_mse, m_sq >> L);
    if (rst) begin
      m_ph = 0; m_ready = 0; m_busy = 0; m_rv = 0;
      m_sum = 0; m_wce = 0; m_cnt = 0; m_sq = 0;
      win.delete(); due = -1;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ph = 1; m_ready = 1; m_busy = 1; win.delete();
        end
        1: if (in_valid) begin
          int e;
          e = int'(in_a) + int'(in_b) - int'(in_o);
          win.push_back(e < 0 ? -e : e);
          if (win.size() == N) begin
            m_ph = 2; m_ready = 0; due = cyc + 3;
          end
        end
        2: if (cyc + 1 == due) begin
          m_ph = 3; m_busy = 0; m_rv = 1;
          m_sum = 0; m_wce = 0; m_cnt = 0; m_sq = 0;
          foreach (win[k]) begin
            m_sum += win[k];
            m_sq  += longint'(win[k]) * win[k];
            if (win[k] != 0) m_cnt++;
            if (win[k] > m_wce) m_wce = win[k];
          end
        end
        3: if (res_ack) begin
          m_ph = 0; m_rv = 0;
        end
        default: m_ph = 0;
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int b, input int o);
    in_a = 8'(a); in_b = 8'(b); in_o = 9'(o);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL rv_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic ack();
    res_ack = 1; tick(); res_ack = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic feed4_zero();
    for (int i = 0; i < 4; i++) begin
      put(i * 40, 255 - i, i * 40 + 255 - i);
      in_valid = 1; tick();
    end
    in_valid = 0;
  endtask

  task automatic lit_all(input string p, input int s, input int w,
                         input int c, input int q);
    chk({p, "_sum"}, r_sabs, s);
    chk({p, "_mae"}, r_mae, s >> L);
    chk({p, "_wce"}, r_wce, w);
    chk({p, "_cnt"}, r_cnt, c);
    chk({p, "_sq"}, r_ssq, q);
    chk({p, "_mse"}, r_mse, q >> L);
  endtask

  int ea[4] = '{1, 10, 0, 200};
  int eb[4] = '{2, 10, 0, 100};
  int eo[4] = '{3, 17, 5, 20};

  initial begin
    longint ms, mq;
    rst = 1; start = 0; in_valid = 0; res_ack = 0; put(0, 0, 0);
    bstart = 0; bvalid = 0; back = 0; ba = 0; bb = 0; bo = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_sum", r_sabs, 0);
    rst = 0;

    pulse_start();
    feed4_zero();
    wait_rv();
    lit_all("zero", 0, 0, 0, 0);
    ack();

    pulse_start();
    for (int i = 0; i < 4; i++) begin
      put(ea[i], eb[i], eo[i]); in_valid = 1; tick();
    end
    in_valid = 0;
    wait_rv();
    lit_all("err", 288, 280, 3, 78434);
    chk("lit_mae", r_mae, 72);
    chk("lit_mse", r_mse, 19608);
    chk("model_sum", m_sum, 288);
    chk("model_sq", m_sq, 78434);
    ack();

    pulse_start();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      put(ea[i/2], eb[i/2], eo[i/2]);
      tick();
      if (i == 6) chk("ready_after_last", in_ready, 0);
    end
    in_valid = 0;
    chk("rv_at_t2", res_valid, 0);
    tick();
    chk("rv_at_t3", res_valid, 1);
    lit_all("tog", 288, 280, 3, 78434);
    ack();

    pulse_start();
    for (int i = 0; i < 2; i++) begin
      put(0, 0, 100); in_valid = 1; tick();
    end
    in_valid = 0;
    rst = 1; tick(); rst = 0;
    chk("abort_busy", busy, 0);
    pulse_start();
    feed4_zero();
    wait_rv();
    lit_all("abort", 0, 0, 0, 0);
    ack();

    pulse_start();
    for (int i = 0; i < 4; i++) begin
      put(i * 50, 7, $urandom_range(0, 511)); in_valid = 1; tick();
    end
    in_valid = 0;
    wait_rv();
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 1); tick();
    end
    chk("hold_rv", res_valid, 1);
    chk("hold_busy", busy, 0);
    res_ack = 1; start = 1; tick();
    chk("ackstart_busy", busy, 0);
    chk("ackstart_rv", res_valid, 0);
    res_ack = 0; start = 1; tick(); start = 0;
    chk("restart_busy", busy, 1);
    chk("restart_ready", in_ready, 1);
    feed4_zero();
    wait_rv();
    ack();

    for (int i = 0; i < 800; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      start = ($urandom_range(0, 9) == 0);
      res_ack = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      put(a, b, $urandom_range(0, 1) ? a + b : $urandom_range(0, 511));
      tick();
    end
    start = 0; res_ack = 0; in_valid = 0;
    tick();

    bstart = 1; tick(); bstart = 0;
    for (int i = 0; i < 65536; i++) begin
      bvalid = 1; ba = 8'(i); bb = 8'(i >> 8); tick();
    end
    bvalid = 0;
    for (int k = 0; k < 10 && !b_rv; k++) tick();
    chk("sweep_rv", b_rv, 1);
    ms = 0; mq = 0;
    for (int i = 0; i < 65536; i++) begin
      longint e;
      e = (i & 255) + (i >> 8);
      ms += e;
      mq += e * e;
    end
    chk("sweep_model_sum", ms, 16711680);
    chk("sweep_sum", b_sabs, 16711680);
    chk("sweep_mae", b_mae, 255);
    chk("sweep_wce", b_wce, 510);
    chk("sweep_cnt", b_cnt, 65535);
    chk("sweep_sq", b_ssq, mq);
    chk("sweep_mse", b_mse, mq >> 16);
    back = 1; tick(); back = 0;
    chk("sweep_ack_rv", b_rv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
